// File: rtl/harq_tx_ctrl_if.sv
// Frame, launch and response signals of the HARQ transmit controller.
// The slave modport is the controller's view; the master modport is the frame source/receiver side.
interface harq_tx_ctrl_if;
    logic        i_enable_ecc;
    logic        i_wvalid;
    logic [31:0] i_wdata;
    logic        o_wready;
    logic        o_tx_valid;
    logic [31:0] o_tx_data;
    logic        o_tx_ecc_en;
    logic        o_tx_seq;
    logic        i_ack;
    logic        i_nack;
    logic        i_rsp_seq;
    logic        o_busy;
    logic        o_fail;
    logic [15:0] o_retx_count;

    modport slave (
        input  i_enable_ecc, i_wvalid, i_wdata, i_ack, i_nack, i_rsp_seq,
        output o_wready, o_tx_valid, o_tx_data, o_tx_ecc_en, o_tx_seq,
        output o_busy, o_fail, o_retx_count
    );

    modport master (
        output i_enable_ecc, i_wvalid, i_wdata, i_ack, i_nack, i_rsp_seq,
        input  o_wready, o_tx_valid, o_tx_data, o_tx_ecc_en, o_tx_seq,
        input  o_busy, o_fail, o_retx_count
    );
endinterface

// File: rtl/harq_tx_ctrl.sv
// Stop-and-wait HARQ transmitter: buffers one frame, launches it, and retransmits
// on matching NACK or timeout until MAX_RETRY is exhausted, then drops the frame.
module harq_tx_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 3
) (
    input  logic            i_aclk,
    input  logic            i_reset,
    harq_tx_ctrl_if.slave   bus
);

    localparam logic [15:0] TIMER_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FAIL
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] buf_reg, buf_next;
    logic        ecc_reg, ecc_next;
    logic        seq_reg, seq_next;
    logic [15:0] timer_reg, timer_next;
    logic [3:0]  retry_reg, retry_next;
    logic [15:0] retx_reg, retx_next;
    logic        tx_valid_reg;

    logic        ack_hit;
    logic        nack_hit;
    logic        timeout_hit;

    assign ack_hit     = bus.i_ack  && (bus.i_rsp_seq == seq_reg);
    assign nack_hit    = bus.i_nack && (bus.i_rsp_seq == seq_reg);
    assign timeout_hit = (timer_reg == TIMER_LAST);

    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        ecc_next   = ecc_reg;
        seq_next   = seq_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        retx_next  = retx_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.i_wvalid) begin
                    buf_next   = bus.i_wdata;
                    ecc_next   = bus.i_enable_ecc;
                    retry_next = 4'd0;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                timer_next = 16'd0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                timer_next = timer_reg + 16'd1;
                // A matching ACK wins over both a simultaneous NACK and the timeout.
                if (ack_hit) begin
                    seq_next   = ~seq_reg;
                    state_next = ST_IDLE;
                end else if (nack_hit || timeout_hit) begin
                    if (retry_reg < RETRY_LIMIT) begin
                        retry_next = retry_reg + 4'd1;
                        if (retx_reg != 16'hFFFF) begin
                            retx_next = retx_reg + 16'd1;
                        end
                        state_next = ST_SEND;
                    end else begin
                        state_next = ST_FAIL;
                    end
                end
            end
            ST_FAIL: begin
                seq_next   = ~seq_reg;
                buf_next   = 32'd0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            buf_reg      <= 32'd0;
            ecc_reg      <= 1'b0;
            seq_reg      <= 1'b0;
            timer_reg    <= 16'd0;
            retry_reg    <= 4'd0;
            retx_reg     <= 16'd0;
            tx_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            buf_reg      <= buf_next;
            ecc_reg      <= ecc_next;
            seq_reg      <= seq_next;
            timer_reg    <= timer_next;
            retry_reg    <= retry_next;
            retx_reg     <= retx_next;
            // Strobe is high exactly during each SEND cycle.
            tx_valid_reg <= (state_next == ST_SEND);
        end
    end

    assign bus.o_wready     = (state_reg == ST_IDLE) && !i_reset;
    assign bus.o_busy       = (state_reg != ST_IDLE) && !i_reset;
    assign bus.o_fail       = (state_reg == ST_FAIL) && !i_reset;
    assign bus.o_tx_valid   = tx_valid_reg;
    assign bus.o_tx_data    = buf_reg;
    assign bus.o_tx_ecc_en  = ecc_reg;
    assign bus.o_tx_seq     = seq_reg;
    assign bus.o_retx_count = retx_reg;

endmodule

// File: tb/tb_harq_tx_ctrl.sv
// Directed bench for harq_tx_ctrl: stimulus pushes expected launches/drops into a
// scoreboard queue; a negedge monitor pops and compares each one the DUT presents.
module tb_harq_tx_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        bit          is_fail;
        int          cyc;
        logic [31:0] data;
        bit          seq;
        bit          ecc;
    } exp_t;

    exp_t sb[$];

    harq_tx_ctrl_if bus ();

    harq_tx_ctrl #(
        .TIMEOUT_CYCLES(64),
        .MAX_RETRY(3)
    ) dut (
        .i_aclk  (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic handle_event(input bit is_fail);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s cyc=%0d actual=1 required=0",
                     is_fail ? "drop" : "launch", cyc);
        end else begin
            e = sb.pop_front();
            chk("event_kind", 64'(is_fail), 64'(e.is_fail));
            chk("event_cycle", 64'(cyc), 64'(e.cyc));
            if (is_fail) begin
                $display("drop   cyc=%0d", cyc);
            end else begin
                chk("launch_data", 64'(bus.o_tx_data), 64'(e.data));
                chk("launch_seq", 64'(bus.o_tx_seq), 64'(e.seq));
                chk("launch_ecc", 64'(bus.o_tx_ecc_en), 64'(e.ecc));
                $display("launch cyc=%0d data=%08h seq=%0d ecc=%0d",
                         cyc, bus.o_tx_data, bus.o_tx_seq, bus.o_tx_ecc_en);
            end
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_tx_valid === 1'b1) handle_event(1'b0);
        if (bus.o_fail === 1'b1) handle_event(1'b1);
    end

    task automatic exp_launch(input int c, input logic [31:0] d, input bit s, input bit e);
        sb.push_back('{is_fail: 1'b0, cyc: c, data: d, seq: s, ecc: e});
    endtask

    task automatic exp_drop(input int c);
        sb.push_back('{is_fail: 1'b1, cyc: c, data: 32'd0, seq: 1'b0, ecc: 1'b0});
    endtask

    task automatic goto_cyc(input int t);
        if (cyc > t) chk("schedule_order", 64'(cyc), 64'(t));
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wready", 64'(bus.o_wready), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_tx_valid", 64'(bus.o_tx_valid), 64'd0);
        chk("rst_tx_data", 64'(bus.o_tx_data), 64'd0);
        chk("rst_ecc", 64'(bus.o_tx_ecc_en), 64'd0);
        chk("rst_seq", 64'(bus.o_tx_seq), 64'd0);
        chk("rst_retx", 64'(bus.o_retx_count), 64'd0);
        chk("rst_fail", 64'(bus.o_fail), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_wready", 64'(bus.o_wready), 64'd1);
    endtask

    task automatic send_frame(input logic [31:0] d, input bit ecc, output int acc);
        int n;
        n = 0;
        while (bus.o_wready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wready_before_accept", 64'(bus.o_wready), 64'd1);
        bus.i_wdata      = d;
        bus.i_enable_ecc = ecc;
        bus.i_wvalid     = 1'b1;
        acc = cyc;
        @(posedge clk);
        #1;
        // Garbage on the upstream bus must not leak into the held frame.
        bus.i_wvalid     = 1'b0;
        bus.i_wdata      = ~d;
        bus.i_enable_ecc = ~ecc;
    endtask

    task automatic respond(input int t, input bit ack, input bit nack, input bit s);
        goto_cyc(t);
        bus.i_ack     = ack;
        bus.i_nack    = nack;
        bus.i_rsp_seq = s;
        @(posedge clk);
        #1;
        bus.i_ack  = 1'b0;
        bus.i_nack = 1'b0;
    endtask

    initial begin
        int a;
        bus.i_enable_ecc = 1'b0;
        bus.i_wvalid     = 1'b0;
        bus.i_wdata      = 32'd0;
        bus.i_ack        = 1'b0;
        bus.i_nack       = 1'b0;
        bus.i_rsp_seq    = 1'b0;
        #1;
        do_reset();

        // Single launch acknowledged five cycles later.
        send_frame(32'hDEADBEEF, 1'b1, a);
        exp_launch(a + 1, 32'hDEADBEEF, 1'b0, 1'b1);
        respond(a + 6, 1'b1, 1'b0, 1'b0);
        goto_cyc(a + 7);
        chk("ack_seq_toggle", 64'(bus.o_tx_seq), 64'd1);
        chk("ack_retx", 64'(bus.o_retx_count), 64'd0);
        chk("ack_idle", 64'(bus.o_wready), 64'd1);

        // Two NACKs then ACK.
        do_reset();
        send_frame(32'h12345678, 1'b0, a);
        exp_launch(a + 1, 32'h12345678, 1'b0, 1'b0);
        exp_launch(a + 4, 32'h12345678, 1'b0, 1'b0);
        exp_launch(a + 8, 32'h12345678, 1'b0, 1'b0);
        respond(a + 3, 1'b0, 1'b1, 1'b0);
        respond(a + 7, 1'b0, 1'b1, 1'b0);
        respond(a + 11, 1'b1, 1'b0, 1'b0);
        goto_cyc(a + 12);
        chk("nack2_retx", 64'(bus.o_retx_count), 64'd2);
        chk("nack2_seq", 64'(bus.o_tx_seq), 64'd1);
        chk("nack2_idle", 64'(bus.o_wready), 64'd1);

        // Silence: three timeouts retransmit, fourth drops the frame.
        do_reset();
        send_frame(32'hA5A50F0F, 1'b1, a);
        exp_launch(a + 1,   32'hA5A50F0F, 1'b0, 1'b1);
        exp_launch(a + 66,  32'hA5A50F0F, 1'b0, 1'b1);
        exp_launch(a + 131, 32'hA5A50F0F, 1'b0, 1'b1);
        exp_launch(a + 196, 32'hA5A50F0F, 1'b0, 1'b1);
        exp_drop(a + 261);
        goto_cyc(a + 200);
        chk("timeout_busy", 64'(bus.o_busy), 64'd1);
        goto_cyc(a + 262);
        chk("timeout_retx", 64'(bus.o_retx_count), 64'd3);
        chk("timeout_seq", 64'(bus.o_tx_seq), 64'd1);
        chk("timeout_idle", 64'(bus.o_wready), 64'd1);
        chk("timeout_buf_cleared", 64'(bus.o_tx_data), 64'd0);

        // Mismatched ACK ignored, ACK+NACK together counts as ACK.
        do_reset();
        send_frame(32'h0BADF00D, 1'b0, a);
        exp_launch(a + 1, 32'h0BADF00D, 1'b0, 1'b0);
        respond(a + 3, 1'b1, 1'b0, 1'b1);
        goto_cyc(a + 4);
        chk("mismatch_ignored_busy", 64'(bus.o_busy), 64'd1);
        respond(a + 5, 1'b1, 1'b1, 1'b0);
        goto_cyc(a + 6);
        chk("acknack_seq", 64'(bus.o_tx_seq), 64'd1);
        chk("acknack_retx", 64'(bus.o_retx_count), 64'd0);
        chk("acknack_idle", 64'(bus.o_wready), 64'd1);
        respond(a + 7, 1'b1, 1'b0, 1'b1);
        respond(a + 9, 1'b0, 1'b1, 1'b1);
        goto_cyc(a + 10);
        chk("idle_rsp_ignored_seq", 64'(bus.o_tx_seq), 64'd1);
        chk("idle_rsp_ignored_busy", 64'(bus.o_busy), 64'd0);

        // Matching ACK lands on the timeout cycle.
        send_frame(32'hCAFEBABE, 1'b1, a);
        exp_launch(a + 1, 32'hCAFEBABE, 1'b1, 1'b1);
        respond(a + 65, 1'b1, 1'b0, 1'b1);
        goto_cyc(a + 66);
        chk("edge_ack_idle", 64'(bus.o_wready), 64'd1);
        chk("edge_ack_seq", 64'(bus.o_tx_seq), 64'd0);
        chk("edge_ack_retx", 64'(bus.o_retx_count), 64'd0);
        goto_cyc(a + 70);

        // Reset while waiting after two retries: abandoned without a drop pulse.
        send_frame(32'h5555AAAA, 1'b1, a);
        exp_launch(a + 1, 32'h5555AAAA, 1'b0, 1'b1);
        exp_launch(a + 4, 32'h5555AAAA, 1'b0, 1'b1);
        exp_launch(a + 8, 32'h5555AAAA, 1'b0, 1'b1);
        respond(a + 3, 1'b0, 1'b1, 1'b0);
        respond(a + 7, 1'b0, 1'b1, 1'b0);
        goto_cyc(a + 10);
        chk("pre_reset_retx", 64'(bus.o_retx_count), 64'd2);
        do_reset();
        goto_cyc(a + 90);
        chk("post_abandon_busy", 64'(bus.o_busy), 64'd0);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/harq_tx_ctrl.md
HARQ_TX_CTRL -- requirements
Module: harq_tx_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning WAIT cycles before implicit NACK (range 2..65535).
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning retransmissions allowed before the frame is dropped (range 0..15).
REQ-003 SHALL have port i_aclk  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_enable_ecc  in  1  ECC enable request, sampled with each accepted frame.
REQ-006 SHALL have port i_wvalid  in  1  upstream frame valid.
REQ-007 SHALL have port i_wdata  in  32  upstream payload.
REQ-008 SHALL have port o_wready  out  1  controller can accept a frame.
REQ-009 SHALL have port o_tx_valid  out  1  one-cycle launch strobe to the ECC encoder.
REQ-010 SHALL have port o_tx_data  out  32  buffered payload to the encoder.
REQ-011 SHALL have port o_tx_ecc_en  out  1  ECC enable held for the frame in flight.
REQ-012 SHALL have port o_tx_seq  out  1  alternating sequence bit of the frame in flight.
REQ-013 SHALL have port i_ack / i_nack / i_rsp_seq  in  1/1/1  receiver response strobes and the sequence bit they refer to.
REQ-014 SHALL have port o_busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port o_fail  out  1  one-cycle pulse when a frame is dropped.
REQ-016 SHALL have port o_retx_count  out  16  saturating count of retransmissions since reset.

Function
REQ-017 SHALL implement states IDLE, SEND, WAIT, FAIL; o_wready SHALL be 1 only in IDLE.
REQ-018 In IDLE, i_wvalid=1 SHALL capture i_wdata into the buffer, i_enable_ecc into o_tx_ecc_en, clear retry count, and go to SEND.
REQ-019 In SEND, o_tx_valid SHALL be 1 for exactly one cycle with o_tx_data=buffer, then state SHALL go to WAIT with timer cleared.
REQ-020 Latency: handshake accepted in cycle N SHALL produce o_tx_valid in cycle N+1; o_tx_valid, o_tx_data, o_tx_seq SHALL be registered.
REQ-021 In WAIT the timer SHALL increment each cycle; i_ack=1 with i_rsp_seq==o_tx_seq SHALL toggle o_tx_seq and go to IDLE.
REQ-022 In WAIT, i_nack=1 with matching i_rsp_seq, or timer == TIMEOUT_CYCLES-1, SHALL retry: if retry count < MAX_RETRY, increment it, increment o_retx_count (saturating at 16'hFFFF), go to SEND; else go to FAIL.
REQ-023 Responses with mismatched i_rsp_seq SHALL be ignored; i_ack/i_nack in IDLE, SEND or FAIL SHALL be ignored.
REQ-024 Simultaneous matching i_ack and i_nack SHALL be treated as ACK; matching ACK in the timeout cycle SHALL take priority over the timeout.
REQ-025 FAIL SHALL last one cycle: o_fail=1, o_tx_seq toggles, buffer discarded, next state IDLE.
REQ-026 Retransmission SHALL resend identical o_tx_data, o_tx_seq and o_tx_ecc_en; buffer SHALL not change outside IDLE capture.
REQ-027 MAX_RETRY=0 SHALL send once and go to FAIL on first NACK/timeout.

Reset
REQ-028 i_reset=1 SHALL, at the next edge regardless of state, force IDLE, o_tx_valid=0, o_tx_data=0, o_tx_ecc_en=0, o_tx_seq=0, o_fail=0, o_retx_count=0, timer and retry count =0.
REQ-029 During reset o_wready SHALL be 0, and o_busy SHALL be 0; a frame in flight at reset SHALL be abandoned without o_fail.

Verification
REQ-030 Frame 32'hDEADBEEF, ecc_en=1, ACK seq0 at 5 cycles after launch -> one o_tx_valid, seq0, ecc_en=1, o_tx_seq becomes 1, o_retx_count=0.
REQ-031 NACK seq0 twice then ACK seq0 -> three identical launches, o_retx_count=2, no o_fail.
REQ-032 No response, MAX_RETRY=3, TIMEOUT_CYCLES=64 -> launches at cycles 1, 66, 131, 196, o_fail at 261, o_retx_count=3, o_tx_seq toggles.
REQ-033 ACK with i_rsp_seq=1 while o_tx_seq=0, then ACK+NACK seq0 same cycle -> first ignored, second accepted as ACK.
REQ-034 i_reset asserted in WAIT after 2 retries -> next cycle IDLE, all outputs zero, o_wready=1 after release, no o_fail.
REQ-035 Matching ACK on cycle timer==TIMEOUT_CYCLES-1 -> goes to IDLE, no retransmission, o_retx_count unchanged.
